// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: the arbiter FSM state
// encoding and the byte width of every requester lane.
package uart_tx_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping circularly, returned both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pickOh,
  output logic [IDX_W-1:0]   pickIdx,
  output logic               anyReq
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    pickOh  = '0;
    pickIdx = '0;
    anyReq  = |req;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pickOh      = '0;
        pickOh[idx] = 1'b1;
        pickIdx     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART DataIn channel between NUM_REQ byte
// streams; grants are held per message and force-released on burst or idle.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [DATA_W*NUM_REQ-1:0] ReqData,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ-1:0]        ReqLast,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic [DATA_W-1:0]         DataIn,
  output logic                      DataInValid,
  input  logic                      DataInReady,
  output logic [NUM_REQ-1:0]        Grant,
  output logic                      Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arbState_t          state, stateNext;
  logic [IDX_W-1:0]   gIdx, gIdxNext;
  logic [IDX_W-1:0]   rrPtr, rrPtrNext;
  logic [NUM_REQ-1:0] grantReg, grantNext;
  logic [7:0]         burstCnt, burstNext;
  logic [7:0]         idleCnt, idleNext;

  logic [NUM_REQ-1:0] pickOh;
  logic [IDX_W-1:0]   pickIdx;
  logic               anyReq;

  logic               gValid;
  logic               gLast;
  logic [DATA_W-1:0]  gData;
  logic               canLoad;
  logic               accept;
  logic               releaseNow;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (ReqValid),
    .ptr     (rrPtr),
    .pickOh  (pickOh),
    .pickIdx (pickIdx),
    .anyReq  (anyReq)
  );

  // Owner lane and handshake; ReqReady follows DataInReady combinationally.
  always_comb begin
    gValid     = ReqValid[gIdx];
    gLast      = ReqLast[gIdx];
    gData      = ReqData[gIdx*DATA_W +: DATA_W];
    canLoad    = !DataInValid || DataInReady;
    accept     = (state == LOCKED) && gValid && canLoad;
    ReqReady   = accept ? grantReg : '0;
    releaseNow = (state == LOCKED) &&
                 ((accept && (gLast || (burstCnt + 8'd1 == 8'(MAX_BURST)))) ||
                  (!gValid && (idleCnt + 8'd1 == 8'(TIMEOUT))));
  end

  always_comb begin
    stateNext = state;
    gIdxNext  = gIdx;
    rrPtrNext = rrPtr;
    grantNext = grantReg;
    burstNext = burstCnt;
    idleNext  = idleCnt;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = LOCKED;
          gIdxNext  = pickIdx;
          grantNext = pickOh;
          burstNext = '0;
          idleNext  = '0;
        end
      end
      LOCKED: begin
        if (releaseNow) begin
          stateNext = IDLE;
          grantNext = '0;
          rrPtrNext = (gIdx == IDX_W'(NUM_REQ - 1)) ? '0 : gIdx + 1'b1;
        end else if (accept) begin
          burstNext = burstCnt + 8'd1;
          idleNext  = '0;
        end else if (!gValid) begin
          idleNext = idleCnt + 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      gIdx     <= '0;
      rrPtr    <= '0;
      grantReg <= '0;
      burstCnt <= '0;
      idleCnt  <= '0;
    end else begin
      state    <= stateNext;
      gIdx     <= gIdxNext;
      rrPtr    <= rrPtrNext;
      grantReg <= grantNext;
      burstCnt <= burstNext;
      idleCnt  <= idleNext;
    end
  end

  // Output stage: holds its byte while the UART stalls, drains after release.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DataIn      <= '0;
      DataInValid <= 1'b0;
    end else if (accept) begin
      DataIn      <= gData;
      DataInValid <= 1'b1;
    end else if (DataInReady) begin
      DataInValid <= 1'b0;
    end
  end

  assign Grant = grantReg;
  assign Busy  = (state == LOCKED) || DataInValid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues feed the DUT,
// expected source order and output bytes are scoreboarded.
module tb_uart_tx_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] ReqData = '0;
  logic [1:0]  ReqValid = '0;
  logic [1:0]  ReqLast = '0;
  logic [1:0]  ReqReady;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b1;
  logic [1:0]  Grant;
  logic        Busy;

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(16), .TIMEOUT(255)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ReqData     (ReqData),
    .ReqValid    (ReqValid),
    .ReqLast     (ReqLast),
    .ReqReady    (ReqReady),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .Grant       (Grant),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  logic [8:0] srcQ[2][$];
  logic [7:0] expQ[$];
  int         srcExp[$];
  int         testsRun = 0;
  int         testsFailed = 0;

  logic [1:0] grantAtNeg, rdyAtNeg;
  logic       busyAtNeg, validAtNeg;
  logic [7:0] dataAtNeg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic last);
    srcQ[r].push_back({last, d});
  endtask

  task automatic drive();
    logic [8:0] head;
    for (int i = 0; i < 2; i++) begin
      if (srcQ[i].size() > 0) begin
        head            = srcQ[i][0];
        ReqValid[i]     = 1'b1;
        ReqData[i*8+:8] = head[7:0];
        ReqLast[i]      = head[8];
      end else begin
        ReqValid[i]     = 1'b0;
        ReqData[i*8+:8] = 8'h00;
        ReqLast[i]      = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [1:0] acc;
    @(negedge Clock);
    grantAtNeg = Grant;
    rdyAtNeg   = ReqReady;
    busyAtNeg  = Busy;
    validAtNeg = DataInValid;
    dataAtNeg  = DataIn;
    acc        = ReqValid & ReqReady;
    if (ReqValid != 2'b00) check("rdyOwner", ReqReady & ~Grant, 0);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        if (srcExp.size() == 0) check("srcExtra", i, 99);
        else check("srcOrder", i, srcExp.pop_front());
      end
    end
    @(posedge Clock);
    #1;
    for (int i = 0; i < 2; i++) if (acc[i]) void'(srcQ[i].pop_front());
    drive();
  endtask

  task automatic runUntilDrained(input int bound, input string tag);
    int n;
    n = 0;
    while ((expQ.size() != 0 || srcExp.size() != 0 || srcQ[0].size() != 0 ||
            srcQ[1].size() != 0 || Grant != 2'b00 || DataInValid) && n < bound) begin
      tick();
      n++;
    end
    check(tag, n < bound, 1);
  endtask

  // Output scoreboard: a byte leaves on every sampled DataInValid & DataInReady.
  always @(negedge Clock) begin
    if (Reset && DataInValid && DataInReady) begin
      if (expQ.size() == 0) check("outExtra", DataIn, 32'h100);
      else check("outData", DataIn, expQ.pop_front());
    end
  end

  initial begin
    int n;
    repeat (2) @(posedge Clock);
    #1;
    check("rstGrant", Grant, 0);
    check("rstReady", ReqReady, 0);
    check("rstValid", DataInValid, 0);
    check("rstData", DataIn, 0);
    check("rstBusy", Busy, 0);
    Reset = 1'b1;
    tick();

    // Single byte with Last: grant at t+1, byte at t+2, then idle.
    send(0, 8'h7a, 1'b1);
    expQ.push_back(8'h7a);
    srcExp.push_back(0);
    drive();
    tick();
    check("s1GrantT0", grantAtNeg, 0);
    tick();
    check("s1GrantT1", grantAtNeg, 2'b01);
    check("s1ReadyT1", rdyAtNeg, 2'b01);
    tick();
    check("s1ValidT2", validAtNeg, 1);
    check("s1DataT2", dataAtNeg, 8'h7a);
    check("s1GrantT2", grantAtNeg, 0);
    tick();
    check("s1ValidT3", validAtNeg, 0);
    check("s1BusyT3", busyAtNeg, 0);

    // Pointer now 1: requester 1 must win a simultaneous request.
    send(0, 8'h31, 1'b0);
    send(0, 8'h32, 1'b1);
    send(1, 8'h41, 1'b1);
    expQ.push_back(8'h41); expQ.push_back(8'h31); expQ.push_back(8'h32);
    srcExp.push_back(1); srcExp.push_back(0); srcExp.push_back(0);
    drive();
    runUntilDrained(50, "s2aDone");

    // UART stall: byte 8'h13 held for 10 cycles while requester 1 waits.
    DataInReady = 1'b0;
    send(1, 8'h13, 1'b0);
    send(1, 8'h14, 1'b1);
    expQ.push_back(8'h13); expQ.push_back(8'h14);
    srcExp.push_back(1); srcExp.push_back(1);
    drive();
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("s5Data", dataAtNeg, 8'h13);
      check("s5Valid", validAtNeg, 1);
      check("s5Ready", rdyAtNeg, 0);
    end
    DataInReady = 1'b1;
    runUntilDrained(20, "s5Done");

    // Burst limit: 16 bytes from req0, then req1's message, then req0 resumes.
    for (int i = 0; i < 20; i++) send(0, 8'(8'h40 + i), 1'b0);
    send(1, 8'hA0, 1'b0);
    send(1, 8'hA1, 1'b1);
    for (int i = 0; i < 16; i++) begin expQ.push_back(8'(8'h40 + i)); srcExp.push_back(0); end
    expQ.push_back(8'hA0); expQ.push_back(8'hA1);
    srcExp.push_back(1); srcExp.push_back(1);
    for (int i = 16; i < 20; i++) begin expQ.push_back(8'(8'h40 + i)); srcExp.push_back(0); end
    drive();
    runUntilDrained(400, "s3Done");

    // Idle timeout: req1 sends one byte without Last, then goes quiet.
    send(1, 8'h55, 1'b0);
    expQ.push_back(8'h55);
    srcExp.push_back(1);
    drive();
    n = 0;
    while (srcQ[1].size() != 0 && n < 10) begin tick(); n++; end
    check("s4Accept", srcQ[1].size(), 0);
    n = 0;
    while (n < 300) begin
      tick();
      if (grantAtNeg == 2'b00) break;
      n++;
    end
    check("s4Timeout", n, 255);
    check("s4Busy", busyAtNeg, 0);

    // Asynchronous reset in the middle of a message drops the held byte.
    send(1, 8'hC0, 1'b0);
    send(1, 8'hC1, 1'b0);
    send(1, 8'hC2, 1'b1);
    srcExp.push_back(1);
    drive();
    tick();
    tick();
    check("s6PreValid", DataInValid, 1);
    Reset = 1'b0;
    #1;
    check("s6Valid", DataInValid, 0);
    check("s6Grant", Grant, 0);
    check("s6Ready", ReqReady, 0);
    check("s6Busy", Busy, 0);
    srcQ[1].delete();
    drive();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    check("s6SrcEmpty", srcExp.size(), 0);

    // Pointer back at 0: two 3-byte messages, req0 first, no interleaving.
    send(0, 8'hBB, 1'b0); send(0, 8'h12, 1'b0); send(0, 8'h21, 1'b1);
    send(1, 8'hBB, 1'b0); send(1, 8'h12, 1'b0); send(1, 8'h21, 1'b1);
    for (int r = 0; r < 2; r++) begin
      expQ.push_back(8'hBB); expQ.push_back(8'h12); expQ.push_back(8'h21);
      srcExp.push_back(r); srcExp.push_back(r); srcExp.push_back(r);
    end
    drive();
    runUntilDrained(60, "s2Done");
    check("finalExpEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel (DataIn/DataInValid/DataInReady) between NUM_REQ byte-stream requesters, for example the CPU memory-mapped UART port and a debug/echo engine.
- Arbitration is round-robin. Each grant is locked per message, meaning until ReqLast is sent.
- A grant is force-released on burst limit or idle timeout, so no requester can starve the others.
- Sits between requesters and the UART DataIn side; one registered output stage.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- TIMEOUT, 255, cycles a granted requester may hold ReqValid low before forced release (1..255).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- ReqData  in  8*NUM_REQ  byte from requester i in bits [8i+7:8i].
- ReqValid  in  NUM_REQ  requester i has a byte.
- ReqLast  in  NUM_REQ  byte from requester i ends its message.
- ReqReady  out  NUM_REQ  byte from requester i accepted this cycle if ReqValid[i].
- DataIn  out  8  byte to UART.
- DataInValid  out  1  DataIn holds a byte.
- DataInReady  in  1  UART accepts DataIn.
- Grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- Busy  out  1  high in LOCKED or while DataInValid is high.

Behaviour:
- Reset (Reset=0, async):
  - State=IDLE, rr pointer=0, burst count=0, idle count=0.
  - Grant=0, ReqReady=0, DataInValid=0, DataIn=8'h00, Busy=0.
  - Reset mid-transfer drops the held byte.
- States:
  - IDLE:
    - If any ReqValid, select the first asserted index at or after the rr pointer (circular).
    - Next cycle: Grant=onehot(g), state=LOCKED, burst count=0, idle count=0.
  - LOCKED:
    - ReqReady[g] = ReqValid[g] & (!DataInValid | DataInReady). All other ReqReady bits are 0.
    - Accept (ReqValid[g]&ReqReady[g]): DataIn<=ReqData[g], DataInValid<=1, burst count+1, idle count=0.
- Output register:
  - DataInValid&DataInReady with no new accept -> DataInValid<=0.
  - DataInValid&!DataInReady -> DataIn and DataInValid held stable.
- Release, evaluated on the same edge as the triggering event:
  - The accepted byte has ReqLast[g].
  - The accepted byte brings burst count to MAX_BURST.
  - Idle count reaches TIMEOUT while ReqValid[g]=0. Idle count increments each LOCKED cycle with ReqValid[g]=0.
- On release:
  - State=IDLE, Grant=0, rr pointer=(g+1) mod NUM_REQ.
  - Simultaneous Last and burst limit produce a single release.
  - The byte still in the output register drains normally. IDLE may re-grant while it drains.
- Latency:
  - ReqValid rising in IDLE at cycle t -> Grant and ReqReady at t+1.
  - First DataInValid at t+2.
  - Steady state: 1 byte/cycle when DataInReady is held high.
- Other rules:
  - Requesters not granted never see ReqReady.
  - ReqValid changes by non-owners have no effect while LOCKED.
  - No combinational path from DataInReady to DataIn.
  - ReqReady depends combinationally on DataInReady.

Decomposition:
- Shared package: state encoding (IDLE, LOCKED), byte width constant 8.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, pointer -> one-hot and index), reusable by other arbiters.

Test Plan:
1. Single requester 0 sends 8'h7a with Last, DataInReady=1 -> Grant=01 at t+1, DataIn=8'h7a with DataInValid at t+2 for one cycle, then IDLE, rr pointer=1.
2. Both request continuously from IDLE with pointer=0, each sending a 3-byte message (8'hBB,8'h12,8'h21 Last) -> req0's 3 bytes, release, req1's 3 bytes, no interleaving.
3. Req0 streams 20 bytes with no Last, MAX_BURST=16, req1 waiting -> exactly 16 bytes from req0, then req1 granted, then req0 resumes.
4. Granted req1 drops ReqValid, TIMEOUT=255 -> Grant clears after 255 idle cycles, Busy=0 once output drained.
5. DataInReady held low 10 cycles with byte 8'h13 pending -> DataIn stable at 8'h13, DataInValid=1, ReqReady[g]=0 throughout; transfer completes the cycle DataInReady rises.
6. Reset asserted mid-message -> DataInValid, Grant and ReqReady go 0 immediately (async); after release, arbitration restarts with pointer=0.
